// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared types and constants for the ray generator
// Purpose: state enum, field widths, error colour and default frame size
//          used by ray_gen and pixel_scan.
// Ports:   none (package).
package ray_pkg;

  localparam int DX_W    = 9;
  localparam int DY_W    = 9;
  localparam int DZ_W    = 10;
  localparam int COLOR_W = 12;
  localparam int ADDR_W  = 17;
  localparam int RAY_W   = DZ_W + DY_W + DX_W;

  localparam logic [COLOR_W-1:0] ERR_COLOR = 12'hF0F;

  localparam int DEF_H_RES = 320;
  localparam int DEF_V_RES = 240;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    WRITE,
    DONE
  } ray_gen_state_t;

endpackage

// File: rtl/pixel_scan.sv
// rtl/pixel_scan.sv - raster scan counters (px, py, linear address)
// Purpose: walks the frame left-to-right, top-to-bottom.
// Ports:   clk_i/rst_i     clock, synchronous active-high reset
//          clr_i           restart at pixel (0,0), address 0
//          adv_i           step to the next pixel
//          nxt_px_o/py_o   counter values after this cycle's clr/adv
//          addr_o          current linear address py*H_RES+px
//          last_o          current pixel is (H_RES-1, V_RES-1)
module pixel_scan
  import ray_pkg::*;
#(
  parameter int H_RES = DEF_H_RES,
  parameter int V_RES = DEF_V_RES
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  output logic [DX_W-1:0]   nxt_px_o,
  output logic [DY_W-1:0]   nxt_py_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  localparam logic [DX_W-1:0] PX_MAX = DX_W'(H_RES - 1);
  localparam logic [DY_W-1:0] PY_MAX = DY_W'(V_RES - 1);

  logic [DX_W-1:0]   px_q, px_d;
  logic [DY_W-1:0]   py_q, py_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    px_d   = px_q;
    py_d   = py_q;
    addr_d = addr_q;
    if (clr_i) begin
      px_d   = '0;
      py_d   = '0;
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = addr_q + ADDR_W'(1);
      if (px_q == PX_MAX) begin
        px_d = '0;
        py_d = py_q + DY_W'(1);
      end else begin
        px_d = px_q + DX_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      px_q   <= '0;
      py_q   <= '0;
      addr_q <= '0;
    end else begin
      px_q   <= px_d;
      py_q   <= py_d;
      addr_q <= addr_d;
    end
  end

  assign nxt_px_o = px_d;
  assign nxt_py_o = py_d;
  assign addr_o   = addr_q;
  assign last_o   = (px_q == PX_MAX) && (py_q == PY_MAX);

endmodule

// File: rtl/ray_gen.sv
// rtl/ray_gen.sv - primary ray issue and framebuffer write sequencer
// Purpose: scans a frame, offers one ray per pixel, waits for the tracer's
//          colour and writes it to the framebuffer. One ray in flight.
// Ports:   clk_i/rst_i          clock, synchronous active-high reset
//          start_i, cam_pos_i   frame start, camera origin (latched)
//          ray_init_o/dir_o     ray origin and {dz, dy, dx} direction
//          ray_valid_o/ready_i  ray handshake
//          tracer_ret_i/dout_i  single-cycle colour return
//          pix_we_o/addr_o/data_o  framebuffer write
//          busy_o, frame_done_o status
// Option:  RAY_GEN_TIMEOUT_EN adds a WAIT watchdog that writes ERR_COLOR.
module ray_gen
  import ray_pkg::*;
#(
  parameter int              H_RES   = DEF_H_RES,
  parameter int              V_RES   = DEF_V_RES,
  parameter logic [DZ_W-1:0] FOCAL   = 10'd256,
  parameter int              TIMEOUT = 1024
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [RAY_W-1:0]   cam_pos_i,
  output logic [RAY_W-1:0]   ray_init_o,
  output logic [RAY_W-1:0]   ray_dir_o,
  output logic               ray_valid_o,
  input  logic               ray_ready_i,
  input  logic               tracer_ret_i,
  input  logic [COLOR_W-1:0] tracer_dout_i,
  output logic               pix_we_o,
  output logic [ADDR_W-1:0]  pix_addr_o,
  output logic [COLOR_W-1:0] pix_data_o,
  output logic               busy_o,
  output logic               frame_done_o
);

  localparam logic [DX_W-1:0] HALF_H = DX_W'(H_RES / 2);
  localparam logic [DY_W-1:0] HALF_V = DY_W'(V_RES / 2);

  ray_gen_state_t     state_q, state_d;
  logic               scan_clr, scan_adv, scan_last;
  logic [DX_W-1:0]    nxt_px;
  logic [DY_W-1:0]    nxt_py;
  logic [RAY_W-1:0]   cam_q, dir_q;
  logic [COLOR_W-1:0] color_q;
  logic               wait_exit;

`ifdef RAY_GEN_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_q;
  logic            wd_expired;

  // Counts cycles spent in WAIT; zero on the first WAIT cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != WAIT) wd_q <= '0;
    else                          wd_q <= wd_q + WD_W'(1);
  end

  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
  assign wait_exit  = tracer_ret_i || wd_expired;
`else
  localparam int unused_timeout = TIMEOUT;
  assign wait_exit = tracer_ret_i;
`endif

  pixel_scan #(
    .H_RES (H_RES),
    .V_RES (V_RES)
  ) u_scan (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (scan_clr),
    .adv_i    (scan_adv),
    .nxt_px_o (nxt_px),
    .nxt_py_o (nxt_py),
    .addr_o   (pix_addr_o),
    .last_o   (scan_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i)     state_d = ISSUE;
      ISSUE:   if (ray_ready_i) state_d = WAIT;
      WAIT:    if (wait_exit)   state_d = WRITE;
      WRITE:   state_d = scan_last ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ray_valid_o  = (state_q == ISSUE);
    pix_we_o     = (state_q == WRITE);
    frame_done_o = (state_q == DONE);
    busy_o       = (state_q != IDLE);
    scan_clr     = (state_q == IDLE) && start_i;
    scan_adv     = (state_q == WRITE);
  end

  // Direction follows the counters' next value so it is ready in ISSUE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cam_q <= '0;
      dir_q <= '0;
    end else begin
      if (scan_clr) cam_q <= cam_pos_i;
      if (scan_clr || scan_adv) dir_q <= {FOCAL, HALF_V - nxt_py, nxt_px - HALF_H};
    end
  end

  // A real return takes priority over watchdog expiry in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      color_q <= '0;
    end else if (state_q == WAIT && tracer_ret_i) begin
      color_q <= tracer_dout_i;
`ifdef RAY_GEN_TIMEOUT_EN
    end else if (state_q == WAIT && wd_expired) begin
      color_q <= ERR_COLOR;
`endif
    end
  end

  assign ray_init_o = cam_q;
  assign ray_dir_o  = dir_q;
  assign pix_data_o = color_q;

endmodule

// File: tb/tb_ray_gen.sv
// tb/tb_ray_gen.sv - self-checking bench for ray_gen
module tb_ray_gen;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic [16:0] addr;
    logic [11:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst, start, ray_valid, ray_ready, tracer_ret;
  logic        pix_we, busy, frame_done;
  logic [27:0] cam_pos, ray_init, ray_dir;
  logic [11:0] tracer_dout, pix_data;
  logic [16:0] pix_addr;

  int  errors = 0;
  int  checks = 0;
  wr_t sb[$];

  always #5 clk = ~clk;

  ray_gen #(
    .H_RES   (H),
    .V_RES   (V),
    .FOCAL   (10'd256),
    .TIMEOUT (TO)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .cam_pos_i     (cam_pos),
    .ray_init_o    (ray_init),
    .ray_dir_o     (ray_dir),
    .ray_valid_o   (ray_valid),
    .ray_ready_i   (ray_ready),
    .tracer_ret_i  (tracer_ret),
    .tracer_dout_i (tracer_dout),
    .pix_we_o      (pix_we),
    .pix_addr_o    (pix_addr),
    .pix_data_o    (pix_data),
    .busy_o        (busy),
    .frame_done_o  (frame_done)
  );

  function automatic logic [27:0] exp_dir(int a);
    logic [8:0] dx, dy;
    dx = 9'((a % H) - H / 2);
    dy = 9'(V / 2 - (a / H));
    return {10'd256, dy, dx};
  endfunction

  task automatic test_reset();
    rst = 1; start = 0; ray_ready = 1; tracer_ret = 0; tracer_dout = '0; cam_pos = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (ray_valid !== 1'b0)  begin errors++; $display("FAIL reset_ray_valid: got %b want 0", ray_valid); end
    checks++; if (pix_we !== 1'b0)     begin errors++; $display("FAIL reset_pix_we: got %b want 0", pix_we); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++; if (pix_addr !== 17'd0)  begin errors++; $display("FAIL reset_pix_addr: got %0d want 0", pix_addr); end
    checks++; if (pix_data !== 12'd0)  begin errors++; $display("FAIL reset_pix_data: got %h want 000", pix_data); end
    checks++; if (ray_dir !== 28'd0)   begin errors++; $display("FAIL reset_ray_dir: got %h want 0", ray_dir); end
    checks++; if (ray_init !== 28'd0)  begin errors++; $display("FAIL reset_ray_init: got %h want 0", ray_init); end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int exp_a = 0, n_wr = 0, last_wr = -100, done_cyc = -1;
    bit pend = 0;
    logic [11:0] pdata = '0;
    wr_t w;
    sb.delete();
    ray_ready = 1; cam_pos = 28'hABCDE12; start = 1;
    @(negedge clk);
    start = 0;
    checks++; if (busy !== 1'b1 || ray_valid !== 1'b1) begin errors++; $display("FAIL start_latency: busy=%b ray_valid=%b want 1 1", busy, ray_valid); end
    checks++; if (ray_init !== 28'hABCDE12) begin errors++; $display("FAIL ray_init: got %h want abcde12", ray_init); end
    for (int cyc = 0; cyc < 60 && done_cyc < 0; cyc++) begin
      tracer_ret = 0;
      if (pend) begin tracer_ret = 1; tracer_dout = pdata; pend = 0; end
      if (pix_we) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL frame_extra_write: addr=%0d none expected", pix_addr); end
        else begin
          w = sb.pop_front();
          if (pix_addr !== w.addr || pix_data !== w.data) begin
            errors++; $display("FAIL frame_write: got addr=%0d data=%h want addr=%0d data=%h", pix_addr, pix_data, w.addr, w.data);
          end
        end
        if (n_wr > 0) begin
          checks++; if (cyc - last_wr != 3) begin errors++; $display("FAIL pixel_period: got %0d want 3", cyc - last_wr); end
        end
        last_wr = cyc; n_wr++;
      end
      if (frame_done) begin
        done_cyc = cyc;
        checks++; if (cyc != last_wr + 1) begin errors++; $display("FAIL done_latency: got %0d want 1", cyc - last_wr); end
      end
      if (ray_valid && ray_ready) begin
        checks++; if (ray_dir !== exp_dir(exp_a)) begin errors++; $display("FAIL ray_dir px%0d: got %h want %h", exp_a, ray_dir, exp_dir(exp_a)); end
        w.addr = 17'(exp_a); w.data = 12'(exp_a + 'h100); sb.push_back(w);
        pend = 1; pdata = w.data; exp_a++;
      end
      @(negedge clk);
    end
    checks++; if (done_cyc < 0) begin errors++; $display("FAIL frame_done_timeout: got none want pulse"); end
    checks++; if (n_wr != 8 || sb.size() != 0) begin errors++; $display("FAIL frame_write_count: got %0d want 8", n_wr); end
    checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL busy_after_done: busy=%b done=%b want 0 0", busy, frame_done); end
  endtask

  task automatic test_backpressure_stray();
    int exp_a = 0, n_wr = 0, stalled = 0;
    bit pend = 0, done = 0;
    logic [11:0] pdata = '0;
    wr_t w;
    sb.delete();
    ray_ready = 1; cam_pos = 28'h1111111; start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 80 && !done; cyc++) begin
      tracer_ret = 0;
      start = (cyc == 14);
      if (pend) begin tracer_ret = 1; tracer_dout = pdata; pend = 0; end
      if (exp_a == 1 && stalled < 5 && (stalled > 0 || ray_valid)) begin
        ray_ready = 0;
        checks++;
        if (ray_valid !== 1'b1 || ray_dir !== exp_dir(1) || pix_we !== 1'b0) begin
          errors++; $display("FAIL stall: valid=%b dir=%h we=%b want 1 %h 0", ray_valid, ray_dir, pix_we, exp_dir(1));
        end
        if (stalled == 2) begin tracer_ret = 1; tracer_dout = 12'hBAD; end
        stalled++;
      end else begin
        ray_ready = 1;
      end
      if (pix_we) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL bp_extra_write: addr=%0d none expected", pix_addr); end
        else begin
          w = sb.pop_front();
          if (pix_addr !== w.addr || pix_data !== w.data) begin
            errors++; $display("FAIL bp_write: got addr=%0d data=%h want addr=%0d data=%h", pix_addr, pix_data, w.addr, w.data);
          end
        end
        n_wr++;
      end
      if (frame_done) done = 1;
      if (ray_valid && ray_ready) begin
        w.addr = 17'(exp_a); w.data = 12'(exp_a + 'h200); sb.push_back(w);
        pend = 1; pdata = w.data; exp_a++;
      end
      @(negedge clk);
    end
    start = 0; ray_ready = 1;
    checks++; if (!done || n_wr != 8 || sb.size() != 0) begin errors++; $display("FAIL bp_frame: done=%b writes=%0d want 1 8", done, n_wr); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int exp_a = 0;
    bit pend = 0, hit = 0, got = 0;
    logic [11:0] pdata = '0;
    wr_t w;
    sb.delete();
    ray_ready = 1; cam_pos = 28'h0F0F0F0; start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 40 && !hit; cyc++) begin
      tracer_ret = 0;
      if (pend) begin
        pend = 0;
        if (exp_a == 4) begin rst = 1; hit = 1; end
        else begin tracer_ret = 1; tracer_dout = pdata; end
      end
      if (pix_we) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rst_extra_write: addr=%0d none expected", pix_addr); end
        else begin
          w = sb.pop_front();
          if (pix_addr !== w.addr || pix_data !== w.data) begin
            errors++; $display("FAIL rst_pre_write: got addr=%0d data=%h want addr=%0d data=%h", pix_addr, pix_data, w.addr, w.data);
          end
        end
      end
      if (!hit && ray_valid && ray_ready) begin
        w.addr = 17'(exp_a); w.data = 12'(exp_a + 'h300); sb.push_back(w);
        pend = 1; pdata = w.data; exp_a++;
      end
      @(negedge clk);
    end
    rst = 0;
    sb.delete();
    checks++; if (!hit) begin errors++; $display("FAIL rst_reach_wait: got no pixel-3 WAIT want one"); end
    checks++; if (busy !== 1'b0 || ray_valid !== 1'b0) begin errors++; $display("FAIL rst_abort: busy=%b valid=%b want 0 0", busy, ray_valid); end
    tracer_ret = 1; tracer_dout = 12'h555;
    @(negedge clk);
    tracer_ret = 0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (pix_we !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL rst_no_write: we=%b done=%b want 0 0", pix_we, frame_done); end
      @(negedge clk);
    end
    start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      tracer_ret = 0;
      if (pend) begin tracer_ret = 1; tracer_dout = 12'h3A0; pend = 0; end
      if (pix_we) begin
        got = 1;
        checks++; if (pix_addr !== 17'd0 || pix_data !== 12'h3A0) begin errors++; $display("FAIL rst_restart: got addr=%0d data=%h want addr=0 data=3a0", pix_addr, pix_data); end
      end
      if (ray_valid && ray_ready) pend = 1;
      @(negedge clk);
    end
    checks++; if (!got) begin errors++; $display("FAIL rst_restart_timeout: got no write want one"); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
  endtask

`ifdef RAY_GEN_TIMEOUT_EN
  task automatic test_timeout();
    int exp_a = 0, wait_start = -1, n_wr = 0;
    bit pend = 0, done = 0;
    logic [11:0] pdata = '0;
    wr_t w;
    sb.delete();
    ray_ready = 1; cam_pos = 28'h2222222; start = 1;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 120 && !done; cyc++) begin
      tracer_ret = 0;
      if (pend) begin tracer_ret = 1; tracer_dout = pdata; pend = 0; end
      if (pix_we) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL to_extra_write: addr=%0d none expected", pix_addr); end
        else begin
          w = sb.pop_front();
          if (pix_addr !== w.addr || pix_data !== w.data) begin
            errors++; $display("FAIL to_write: got addr=%0d data=%h want addr=%0d data=%h", pix_addr, pix_data, w.addr, w.data);
          end
          if (w.addr == 17'd2) begin
            checks++; if (cyc - wait_start != TO) begin errors++; $display("FAIL to_latency: got %0d want %0d", cyc - wait_start, TO); end
          end
        end
        n_wr++;
      end
      if (frame_done) done = 1;
      if (ray_valid && ray_ready) begin
        w.addr = 17'(exp_a);
        if (exp_a == 2) begin
          w.data = 12'hF0F; wait_start = cyc + 1;
        end else begin
          w.data = 12'(exp_a + 'h400); pend = 1; pdata = w.data;
        end
        sb.push_back(w);
        exp_a++;
      end
      @(negedge clk);
    end
    checks++; if (!done || n_wr != 8) begin errors++; $display("FAIL to_frame: done=%b writes=%0d want 1 8", done, n_wr); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure_stray();
    test_reset_mid_frame();
`ifdef RAY_GEN_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ray_gen.md
# ray_gen

Upstream stage of the ray tracer: scans the frame pixel by pixel and issues one primary ray per pixel as a 28-bit origin/direction pair. It waits for the tracer's return pulse and captures the 12-bit colour. It then emits one framebuffer write per pixel. Only one ray is outstanding at a time.

## Interface
- `H_RES`, 320: pixels per line; must be even and ≤ 510.
- `V_RES`, 240: lines per frame; must be even and ≤ 510.
- `FOCAL`, 10'd256: dz component of every ray, unsigned, 10 bits.
- `TIMEOUT`, 1024: watchdog limit in cycles; used only with the macro.
- Clocking: one clock; reset is synchronous and active-high.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `start`  in  1  pulse that begins a frame; ignored while `busy`.
- `cam_pos`  in  28  camera origin; latched on accepted `start`.
- `ray_init`  out  28  ray origin, equal to the latched `cam_pos`.
- `ray_dir`  out  28  ray direction as {dz[9:0], dy[8:0] signed, dx[8:0] signed}.
- `ray_valid`  out  1  ray offered to the tracer.
- `ray_ready`  in  1  tracer accepts the ray.
- `tracer_ret`  in  1  tracer result valid, single-cycle pulse.
- `tracer_dout`  in  12  RGB444 colour from the tracer.
- `pix_we`  out  1  framebuffer write strobe.
- `pix_addr`  out  17  framebuffer address, py*H_RES+px.
- `pix_data`  out  12  colour to write.
- `busy`  out  1  frame in progress.
- `frame_done`  out  1  one-cycle pulse after the last write.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WRITE, DONE.
- IDLE
  - On `start`, latch `cam_pos` and set px=py=addr=0.
  - Go to ISSUE.
- ISSUE
  - `ray_valid`=1; `ray_dir`/`ray_init` stable while `ray_valid`=1 and `ray_ready`=0.
  - Transfer happens on a cycle where `ray_valid` and `ray_ready` are both 1; then go to WAIT.
- WAIT
  - On `tracer_ret`=1, register `tracer_dout` and go to WRITE.
  - `tracer_ret` in any other state is ignored, including stray pulses.
- WRITE
  - `pix_we`=1 for exactly one cycle, with `pix_addr`=addr and `pix_data`=captured colour.
  - Advance the scan. If px=H_RES-1: px←0, py←py+1. Otherwise px←px+1. addr←addr+1 in both cases.
  - If the written pixel was (H_RES-1, V_RES-1), go to DONE; else go to ISSUE.
- DONE: `frame_done`=1 for one cycle, then go to IDLE.
- Direction arithmetic (registered with the scan counters):
  - dx = px − H_RES/2, range −H_RES/2 … H_RES/2−1.
  - dy = V_RES/2 − py, range −V_RES/2+1 … V_RES/2.
  - Both fit in 9-bit two's complement; no saturation is needed.
  - dz = FOCAL.
- `busy`=1 in every state except IDLE.
- `rst` mid-frame:
  - Abort immediately; go to IDLE.
  - No further `pix_we` and no `frame_done` for the aborted frame.
  - A pending `tracer_ret` is dropped.

## Timing
- Reset values: `ray_valid`=0, `pix_we`=0, `frame_done`=0, `busy`=0, `pix_addr`=0, `pix_data`=0, `ray_dir`=0, `ray_init`=0.
- `start` at cycle N: `busy`=1 and `ray_valid`=1 at N+1.
- Minimum per-pixel period is 3 cycles (ISSUE → WAIT → WRITE), with `ray_ready` held high and `tracer_ret` arriving in the first WAIT cycle.
- `tracer_ret` at cycle M: `pix_we`=1 at M+1.
- Last `pix_we` at cycle K: `frame_done`=1 at K+1, `busy`=0 at K+2.
- `start` during DONE is ignored; `start` one cycle after DONE (in IDLE) is accepted.

## Configuration
- Macro: `RAY_GEN_TIMEOUT_EN`.
- Defined:
  - A cycle counter runs in WAIT.
  - If TIMEOUT cycles pass without `tracer_ret`, go to WRITE with `pix_data`=12'hF0F (error magenta). The frame continues.
  - A `tracer_ret` that coincides with expiry wins, and its colour is written.
- Undefined: WAIT waits indefinitely; no counter logic is compiled.

## Structure
- Package `ray_pkg` holds:
  - the state enum `ray_gen_state_t`;
  - field widths `DX_W=9`, `DY_W=9`, `DZ_W=10`, `COLOR_W=12`, `ADDR_W=17`;
  - `ERR_COLOR=12'hF0F`;
  - default `H_RES`/`V_RES`.
- One sub-module, `pixel_scan`, holds the px/py/addr counters with `clr`, `adv`, and `last` outputs. The FSM and the direction math stay in `ray_gen`.

## Test plan
- Single frame: H_RES=4, V_RES=2, `ray_ready`=1, and the tracer returns `tracer_dout`=addr+12'h100 one cycle after each ray.
  - Expect 8 writes, addr 0..7, data 12'h100..12'h107, 3 cycles apart.
  - Expect `frame_done` one cycle after addr 7.
- Direction values: H_RES=4, V_RES=2, FOCAL=256.
  - Pixel 0 → `ray_dir`={10'd256, 9'd1, −9'd2}.
  - Pixel 7 → {10'd256, 9'd0, 9'd1}.
- Backpressure: hold `ray_ready`=0 for 5 cycles.
  - `ray_valid` stays high and `ray_dir` stays stable.
  - No `pix_we` during the stall.
- Stray and ignored inputs:
  - `tracer_ret` pulsed in ISSUE → ignored, no write.
  - `start` pulsed mid-frame → ignored, addr sequence unchanged.
- Reset mid-frame: assert `rst` in WAIT at pixel 3.
  - Next cycle: `busy`=0, `ray_valid`=0.
  - A later `tracer_ret` causes no write.
  - A new `start` restarts at addr 0.
- With `RAY_GEN_TIMEOUT_EN` and TIMEOUT=16: the tracer never returns for pixel 2.
  - Write of 12'hF0F at addr 2, 16 cycles after entering WAIT.
  - The frame then completes.
